datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 171 +++++++++++++++++
 tb/tb_datapath.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// 32-bit register-file datapath: one shared bus, sixteen general registers,
// HI/LO/PC/IR/MAR/Y/In_Port/C/MDR, and a 64-bit Z register fed by the ALU.
// Ports:
//   clock, clear               clock and async active-low reset
//   R0in..R15in, HIin..Coutin  per-register load enables (from bus)
//   Zhighin/Zlowin, Zin        load a half of Z from bus / full ALU result
//   MDRin, Read                MDR load; Read picks Mdatain over bus
//   R0out..Coutout             bus drivers (fixed priority, R0 highest)
//   IncPC                      ALU result forced to bus + 1
//   Mdatain, ALU_Control       memory data in, ALU opcode
//   Out_Portout                combinational bus value
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, PCin, IRin, MARin, Yin, In_Portin, Coutin,
  input  logic        Zhighin, Zlowin, Zin, MDRin, Read,
  input  logic        R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout,
  input  logic        IncPC,
  input  logic [31:0] Mdatain,
  input  logic [4:0]  ALU_Control,
  output logic [31:0] Out_Portout
);
  localparam int unsigned W = 32;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  logic [W-1:0]   bus;
  logic [15:0]    r_in, r_out;
  logic [W-1:0]   r_q [16];
  logic [W-1:0]   hi_q, lo_q, pc_q, ir_q, mar_q, y_q, in_port_q, cout_q, mdr_q;
  logic [2*W-1:0] z_q, alu, rol, prod;
  logic [4:0]     sh;
  logic           unused_ok;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  // General registers, addressable by instance name
  reg32 R0  (.clk(clock), .rst_n(clear), .en(r_in[0]),  .d(bus), .q(r_q[0]));
  reg32 R1  (.clk(clock), .rst_n(clear), .en(r_in[1]),  .d(bus), .q(r_q[1]));
  reg32 R2  (.clk(clock), .rst_n(clear), .en(r_in[2]),  .d(bus), .q(r_q[2]));
  reg32 R3  (.clk(clock), .rst_n(clear), .en(r_in[3]),  .d(bus), .q(r_q[3]));
  reg32 R4  (.clk(clock), .rst_n(clear), .en(r_in[4]),  .d(bus), .q(r_q[4]));
  reg32 R5  (.clk(clock), .rst_n(clear), .en(r_in[5]),  .d(bus), .q(r_q[5]));
  reg32 R6  (.clk(clock), .rst_n(clear), .en(r_in[6]),  .d(bus), .q(r_q[6]));
  reg32 R7  (.clk(clock), .rst_n(clear), .en(r_in[7]),  .d(bus), .q(r_q[7]));
  reg32 R8  (.clk(clock), .rst_n(clear), .en(r_in[8]),  .d(bus), .q(r_q[8]));
  reg32 R9  (.clk(clock), .rst_n(clear), .en(r_in[9]),  .d(bus), .q(r_q[9]));
  reg32 R10 (.clk(clock), .rst_n(clear), .en(r_in[10]), .d(bus), .q(r_q[10]));
  reg32 R11 (.clk(clock), .rst_n(clear), .en(r_in[11]), .d(bus), .q(r_q[11]));
  reg32 R12 (.clk(clock), .rst_n(clear), .en(r_in[12]), .d(bus), .q(r_q[12]));
  reg32 R13 (.clk(clock), .rst_n(clear), .en(r_in[13]), .d(bus), .q(r_q[13]));
  reg32 R14 (.clk(clock), .rst_n(clear), .en(r_in[14]), .d(bus), .q(r_q[14]));
  reg32 R15 (.clk(clock), .rst_n(clear), .en(r_in[15]), .d(bus), .q(r_q[15]));

  // Special-purpose registers loaded straight from the bus
  reg32 hi      (.clk(clock), .rst_n(clear), .en(HIin),      .d(bus), .q(hi_q));
  reg32 lo      (.clk(clock), .rst_n(clear), .en(LOin),      .d(bus), .q(lo_q));
  reg32 pc      (.clk(clock), .rst_n(clear), .en(PCin),      .d(bus), .q(pc_q));
  reg32 ir      (.clk(clock), .rst_n(clear), .en(IRin),      .d(bus), .q(ir_q));
  reg32 mar     (.clk(clock), .rst_n(clear), .en(MARin),     .d(bus), .q(mar_q));
  reg32 y       (.clk(clock), .rst_n(clear), .en(Yin),       .d(bus), .q(y_q));
  reg32 in_port (.clk(clock), .rst_n(clear), .en(In_Portin), .d(bus), .q(in_port_q));
  reg32 cout    (.clk(clock), .rst_n(clear), .en(Coutin),    .d(bus), .q(cout_q));

  // IR and MAR feed logic outside this block; only observed hierarchically here
  assign unused_ok = ^{ir_q, mar_q};

  // MDR: memory data when Read, otherwise bus
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)     mdr_q <= '0;
    else if (MDRin) mdr_q <= Read ? Mdatain : bus;
  end

  // Z: full ALU load takes precedence over half loads
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      z_q <= '0;
    end else if (Zin) begin
      z_q <= alu;
    end else begin
      if (Zhighin) z_q[2*W-1:W] <= bus;
      if (Zlowin)  z_q[W-1:0]   <= bus;
    end
  end

  // Bus mux: later assignments win, so R0 ends up highest priority
  always_comb begin
    bus = '0;
    if (Coutout)    bus = cout_q;
    if (In_Portout) bus = in_port_q;
    if (MDRout)     bus = mdr_q;
    if (PCout)      bus = pc_q;
    if (Zlowout)    bus = z_q[W-1:0];
    if (Zhighout)   bus = z_q[2*W-1:W];
    if (LOout)      bus = lo_q;
    if (HIout)      bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) bus = r_q[i];
    end
  end

  assign Out_Portout = bus;

  // ALU: A = Y, B = bus
  always_comb begin
    alu  = '0;
    sh   = bus[4:0];
    rol  = {y_q, y_q} << sh;
    prod = 64'($signed(y_q)) * 64'($signed(bus));
    if (IncPC) begin
      alu[W-1:0] = bus + W'(1);
    end else begin
      case (ALU_Control)
        OP_ADD:  alu[W-1:0] = y_q + bus;
        OP_SUB:  alu[W-1:0] = y_q - bus;
        OP_AND:  alu[W-1:0] = y_q & bus;
        OP_OR:   alu[W-1:0] = y_q | bus;
        OP_SHR:  alu[W-1:0] = y_q >> sh;
        OP_SHRA: alu[W-1:0] = W'($signed(y_q) >>> sh);
        OP_SHL:  alu[W-1:0] = y_q << sh;
        OP_ROR:  alu[W-1:0] = W'({y_q, y_q} >> sh);
        OP_ROL:  alu[W-1:0] = rol[2*W-1:W];
        OP_MUL:  alu        = prod;
        OP_DIV: begin
          if (bus != '0) begin
            alu[W-1:0]   = W'($signed(y_q) / $signed(bus));
            alu[2*W-1:W] = W'($signed(y_q) % $signed(bus));
          end
        end
        OP_NEG:  alu[W-1:0] = -bus;
        OP_NOT:  alu[W-1:0] = ~bus;
        default: alu        = '0;
      endcase
    end
  end
endmodule

// Plain loadable 32-bit register with async clear
module reg32 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
  localparam int OBS_BUS = 0, OBS_R0 = 1, OBS_R3 = 2, OBS_R4 = 3, OBS_R7 = 4,
                 OBS_PC = 5, OBS_MAR = 6, OBS_IR = 7, OBS_ZH = 8, OBS_ZL = 9, OBS_Y = 10;

  logic        clock, clear;
  logic [15:0] rin, rout;
  logic HIin, LOin, PCin, IRin, MARin, Yin, In_Portin, Coutin;
  logic Zhighin, Zlowin, Zin, MDRin, Read;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout, IncPC;
  logic [31:0] Mdatain, Out_Portout;
  logic [4:0]  ALU_Control;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t  sb[$];
  event chk_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, lo, hi;
  } vec_t;
  vec_t vt [16];

  datapath dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin),
    .In_Portin(In_Portin), .Coutin(Coutin),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .Zin(Zin), .MDRin(MDRin), .Read(Read),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .In_Portout(In_Portout), .Coutout(Coutout),
    .IncPC(IncPC), .Mdatain(Mdatain), .ALU_Control(ALU_Control),
    .Out_Portout(Out_Portout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] obs(int sel);
    case (sel)
      OBS_BUS: return Out_Portout;
      OBS_R0:  return dut.R0.q;
      OBS_R3:  return dut.R3.q;
      OBS_R4:  return dut.R4.q;
      OBS_R7:  return dut.R7.q;
      OBS_PC:  return dut.pc.q;
      OBS_MAR: return dut.mar.q;
      OBS_IR:  return dut.ir.q;
      OBS_ZH:  return dut.z_q[63:32];
      OBS_ZL:  return dut.z_q[31:0];
      OBS_Y:   return dut.y.q;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: drains the scoreboard whenever the stimulus marks a sample point
  initial begin
    sb_t  it;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        it  = sb.pop_front();
        act = obs(it.sel);
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    sb.push_back('{name, sel, v});
    -> chk_ev;
    #1;
  endtask

  task automatic ctl_idle();
    rin = '0; rout = '0;
    HIin = 0; LOin = 0; PCin = 0; IRin = 0; MARin = 0; Yin = 0; In_Portin = 0; Coutin = 0;
    Zhighin = 0; Zlowin = 0; Zin = 0; MDRin = 0; Read = 0;
    HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
    In_Portout = 0; Coutout = 0; IncPC = 0;
    Mdatain = '0; ALU_Control = '0;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    ctl_idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Read = 1; MDRin = 1; Mdatain = v;
    cycle();
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Yin = 1;
    cycle();
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    load_y(a);
    load_mdr(b);
    MDRout = 1; ALU_Control = op; Zin = 1;
    cycle();
  endtask

  initial begin
    vt[0]  = '{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0};
    vt[1]  = '{5'd0,  32'h12345678, 32'h11111111, 32'h23456789, 32'h0};
    vt[2]  = '{5'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0};
    vt[3]  = '{5'd1,  32'h0000000A, 32'h00000003, 32'h00000007, 32'h0};
    vt[4]  = '{5'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0};
    vt[5]  = '{5'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0};
    vt[6]  = '{5'd4,  32'h80000010, 32'h00000004, 32'h08000001, 32'h0};
    vt[7]  = '{5'd5,  32'h80000010, 32'h00000004, 32'hF8000001, 32'h0};
    vt[8]  = '{5'd6,  32'h00000001, 32'h00000025, 32'h00000020, 32'h0};
    vt[9]  = '{5'd7,  32'h80000011, 32'h00000004, 32'h18000001, 32'h0};
    vt[10] = '{5'd8,  32'h80000011, 32'h00000004, 32'h00000118, 32'h0};
    vt[11] = '{5'd7,  32'h12345678, 32'h00000000, 32'h12345678, 32'h0};
    vt[12] = '{5'd11, 32'h00000000, 32'h00000005, 32'hFFFFFFFB, 32'h0};
    vt[13] = '{5'd12, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 32'h0};
    vt[14] = '{5'd10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vt[15] = '{5'd31, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0};

    ctl_idle();
    clear = 0;
    repeat (2) @(posedge clock);
    #1;
    expect_val("reset_bus", OBS_BUS, 32'h0);
    expect_val("reset_r0", OBS_R0, 32'h0);
    expect_val("reset_pc", OBS_PC, 32'h0);
    expect_val("reset_zl", OBS_ZL, 32'h0);
    clear = 1;
    cycle();
    expect_val("idle_bus_zero", OBS_BUS, 32'h0);

    // Shift-left sequence: R7 = 0x34 << (0x45 & 31)
    load_mdr(32'h34);
    MDRout = 1; rin[0] = 1; cycle();
    load_mdr(32'h45);
    MDRout = 1; rin[4] = 1; cycle();
    rout[0] = 1; Yin = 1; cycle();
    rout[4] = 1; ALU_Control = 5'd6; Zin = 1; cycle();
    Zlowout = 1; rin[7] = 1; cycle();
    expect_val("shl_r0", OBS_R0, 32'h34);
    expect_val("shl_r4", OBS_R4, 32'h45);
    expect_val("shl_r7", OBS_R7, 32'h00000680);

    // Instruction fetch with IncPC
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; cycle();
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h112B0000; cycle();
    MDRout = 1; IRin = 1; cycle();
    expect_val("fetch_pc", OBS_PC, 32'h1);
    expect_val("fetch_mar", OBS_MAR, 32'h0);
    expect_val("fetch_ir", OBS_IR, 32'h112B0000);

    // Signed multiply
    alu_op(5'd9, 32'hFFFFFFFF, 32'h2);
    expect_val("mul_zh", OBS_ZH, 32'hFFFFFFFF);
    expect_val("mul_zl", OBS_ZL, 32'hFFFFFFFE);
    Zhighout = 1; #1;
    expect_val("zhighout_bus", OBS_BUS, 32'hFFFFFFFF);
    ctl_idle();

    // Divide, then divide by zero clears Z
    alu_op(5'd10, 32'h7, 32'h2);
    expect_val("div_zl", OBS_ZL, 32'h3);
    expect_val("div_zh", OBS_ZH, 32'h1);
    MDRin = 1; Mdatain = 32'h0; Read = 1; cycle();
    MDRout = 1; ALU_Control = 5'd10; Zin = 1; cycle();
    expect_val("div0_zl", OBS_ZL, 32'h0);
    expect_val("div0_zh", OBS_ZH, 32'h0);

    // Directed ALU vectors
    for (int i = 0; i < 16; i++) begin
      alu_op(vt[i].op, vt[i].a, vt[i].b);
      expect_val($sformatf("alu%0d_lo", i), OBS_ZL, vt[i].lo);
      expect_val($sformatf("alu%0d_hi", i), OBS_ZH, vt[i].hi);
    end

    // IncPC overrides opcode and wraps
    load_mdr(32'hFFFFFFFF);
    MDRout = 1; IncPC = 1; ALU_Control = 5'd1; Zin = 1; cycle();
    expect_val("incpc_wrap", OBS_ZL, 32'h0);

    // Zin beats Zlowin in the same cycle
    alu_op(5'd0, 32'h1, 32'h5);
    load_mdr(32'h9);
    MDRout = 1; Zin = 1; Zlowin = 1; cycle();
    expect_val("zin_wins", OBS_ZL, 32'hA);

    // Bus source and priority
    load_mdr(32'h1234);
    MDRout = 1; rin[3] = 1; cycle();
    load_mdr(32'h55);
    rout[3] = 1; #1;
    expect_val("bus_r3", OBS_BUS, 32'h1234);
    MDRout = 1; #1;
    expect_val("bus_prio_r3_mdr", OBS_BUS, 32'h1234);
    rout[3] = 0; #1;
    expect_val("bus_mdr", OBS_BUS, 32'h55);
    ctl_idle(); #1;
    expect_val("bus_none", OBS_BUS, 32'h0);

    // Read=1 ignores bus
    rout[3] = 1; MDRin = 1; Read = 1; Mdatain = 32'hCAFE0001; cycle();
    MDRout = 1; #1;
    expect_val("mdr_read_src", OBS_BUS, 32'hCAFE0001);
    ctl_idle();

    // Asynchronous reset mid-cycle, no clock edge needed
    @(posedge clock);
    #2;
    clear = 0;
    #1;
    expect_val("async_r7", OBS_R7, 32'h0);
    expect_val("async_pc", OBS_PC, 32'h0);
    expect_val("async_zh", OBS_ZH, 32'h0);
    rin[7] = 1; Zhighin = 1;
    repeat (2) @(posedge clock);
    #1;
    ctl_idle();
    clear = 1;
    #1;
    expect_val("post_reset_r7", OBS_R7, 32'h0);
    expect_val("post_reset_y", OBS_Y, 32'h0);
    expect_val("post_reset_bus", OBS_BUS, 32'h0);

    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
